// File: rtl/pkt_channel_demux_pkg.sv
// pkt_channel_demux_pkg
//   Shared types for the packet channel demultiplexer.
//   flit_t  : one stream beat as stored in the output FIFOs.
//   state_t : per-input packet state (IDLE / PASS / DROP).
//   CH_*    : channel tag values that select an output port.
package pkt_channel_demux_pkg;

    typedef struct packed {
        logic [511:0] data;
        logic         sop;
        logic         eop;
        logic [5:0]   empty;
    } flit_t;

    localparam logic CH_NO_CHECK = 1'b0;
    localparam logic CH_CHECK    = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

endpackage

// File: rtl/pkt_channel_demux_fifo.sv
// pkt_flit_fifo
//   Synchronous show-ahead FIFO of flit_t with an occupancy output.
//   Up to two entries can be written per cycle: wr_flit first, then
//   wr2_flit (wr2_en is only meaningful together with wr_en).
//   Ports:
//     clk, rst            clock, synchronous active-high flush
//     wr_en, wr_flit      first write this cycle
//     wr2_en, wr2_flit    second write this cycle (lands after wr_flit)
//     rd_en               pop request; a pop happens on rd_en & rd_valid
//     rd_flit, rd_valid   head entry and non-empty flag
//     used                entries currently stored
module pkt_flit_fifo
    import pkt_channel_demux_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  flit_t                    wr_flit,
    input  logic                     wr2_en,
    input  flit_t                    wr2_flit,
    input  logic                     rd_en,
    output flit_t                    rd_flit,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   used
);

    localparam int AW = $clog2(DEPTH);

    flit_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   wr_cnt;
    logic          pop;

    assign wr_cnt   = (AW+1)'(wr_en) + (AW+1)'(wr2_en);
    assign rd_valid = (used != '0);
    assign pop      = rd_en & rd_valid;
    assign rd_flit  = mem[rd_ptr];

    // Storage carries no reset; only pointers and occupancy are flushed.
    always_ff @(posedge clk) begin
        if (wr_en)  mem[wr_ptr]          <= wr_flit;
        if (wr2_en) mem[wr_ptr + AW'(1)] <= wr2_flit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            wr_ptr <= wr_ptr + wr_cnt[AW-1:0];
            rd_ptr <= rd_ptr + AW'(pop);
            used   <= used + wr_cnt - (AW+1)'(pop);
        end
    end

    // Admission reserves space up front, so writes never exceed capacity
    // even without credit for a same-cycle pop.
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        (int'(used) + int'(wr_cnt)) <= DEPTH);

endmodule

// File: rtl/pkt_channel_demux.sv
// pkt_channel_demux
//   Steers packets from the traffic manager to port 0 (no-check) or
//   port 1 (check) by channel tag, each through its own FIFO. Upstream
//   never stalls, so flow control is a registered almost_full plus a
//   per-packet space reservation of MAX_PKT_FLITS at sop.
//   Ports:
//     clk, rst                      clock, synchronous active-high reset
//     in_pkt_*                      input stream (ready tied high)
//     in_pkt_almost_full            registered backpressure
//     out0_pkt_*, out1_pkt_*        output streams, show-ahead
//     drop_cnt, trunc_cnt           dropped / truncated packet counts
module pkt_channel_demux
    import pkt_channel_demux_pkg::*;
#(
    parameter int DEPTH         = 512,
    parameter int MAX_PKT_FLITS = 32,
    parameter int AF_MARGIN     = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] in_pkt_data,
    input  logic         in_pkt_valid,
    input  logic         in_pkt_sop,
    input  logic         in_pkt_eop,
    input  logic [5:0]   in_pkt_empty,
    input  logic [1:0]   in_pkt_channel,
    output logic         in_pkt_ready,
    output logic         in_pkt_almost_full,
    output logic [511:0] out0_pkt_data,
    output logic         out0_pkt_valid,
    output logic         out0_pkt_sop,
    output logic         out0_pkt_eop,
    output logic [5:0]   out0_pkt_empty,
    input  logic         out0_pkt_ready,
    output logic [511:0] out1_pkt_data,
    output logic         out1_pkt_valid,
    output logic         out1_pkt_sop,
    output logic         out1_pkt_eop,
    output logic [5:0]   out1_pkt_empty,
    input  logic         out1_pkt_ready,
    output logic [31:0]  drop_cnt,
    output logic [31:0]  trunc_cnt
);

    localparam int UW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(MAX_PKT_FLITS + 1);

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          ch, ch_next;
    logic          drop_inc, trunc_inc;
    logic          af_next;
    logic [1:0]    wr_en, wr2_en;
    flit_t         wr_flit [2];
    flit_t         in_flit;
    flit_t         head [2];
    logic [1:0]    head_valid;
    logic [UW-1:0] used [2];
    logic          new_ch;
    logic          marker_same;
    logic          admit;
    int            free_sel;

    assign in_pkt_ready = 1'b1;
    assign in_flit      = '{data: in_pkt_data, sop: in_pkt_sop, eop: in_pkt_eop, empty: in_pkt_empty};
    assign new_ch       = in_pkt_channel[0];

    // A sop that interrupts a PASS packet on the same FIFO also writes a
    // marker there this cycle; that slot is taken out of the free space
    // seen by the new packet so its full reservation stays intact.
    assign marker_same = (state == PASS) && (ch == new_ch);
    assign free_sel    = DEPTH - int'(used[new_ch]) - int'(marker_same);
    assign admit       = (in_pkt_channel < 2'd2) && (free_sel >= MAX_PKT_FLITS);

    always_comb begin
        logic start;
        state_next = state;
        cnt_next   = cnt;
        ch_next    = ch;
        drop_inc   = 1'b0;
        trunc_inc  = 1'b0;
        wr_en      = '0;
        wr2_en     = '0;
        wr_flit[0] = in_flit;
        wr_flit[1] = in_flit;
        start      = 1'b0;
        if (in_pkt_valid) begin
            unique case (state)
                IDLE: start = in_pkt_sop;
                PASS: begin
                    if (in_pkt_sop) begin
                        // Close the interrupted packet with an eop marker.
                        wr_en[ch]   = 1'b1;
                        wr_flit[ch] = '{data: in_pkt_data, sop: 1'b0, eop: 1'b1, empty: 6'd0};
                        trunc_inc   = 1'b1;
                        start       = 1'b1;
                    end else begin
                        wr_en[ch] = 1'b1;
                        cnt_next  = cnt + CW'(1);
                        if (in_pkt_eop) begin
                            state_next = IDLE;
                        end else if (cnt + CW'(1) == CW'(MAX_PKT_FLITS)) begin
                            wr_flit[ch].eop   = 1'b1;
                            wr_flit[ch].empty = 6'd0;
                            trunc_inc         = 1'b1;
                            state_next        = DROP;
                        end
                    end
                end
                DROP: begin
                    if (in_pkt_sop)      start      = 1'b1;
                    else if (in_pkt_eop) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
            if (start) begin
                ch_next = new_ch;
                if (admit) begin
                    cnt_next   = CW'(1);
                    state_next = in_pkt_eop ? IDLE : PASS;
                    if (marker_same) wr2_en[new_ch] = 1'b1;
                    else             wr_en[new_ch]  = 1'b1;
                end else begin
                    drop_inc   = 1'b1;
                    state_next = in_pkt_eop ? IDLE : DROP;
                end
            end
        end
    end

    // Occupancy for almost_full counts this cycle's writes but not its pops.
    always_comb begin
        af_next = 1'b0;
        for (int n = 0; n < 2; n++) begin
            if ((int'(used[n]) + int'(wr_en[n]) + int'(wr2_en[n])) >= (DEPTH - AF_MARGIN))
                af_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            cnt                <= '0;
            ch                 <= CH_NO_CHECK;
            drop_cnt           <= '0;
            trunc_cnt          <= '0;
            in_pkt_almost_full <= 1'b0;
        end else begin
            state              <= state_next;
            cnt                <= cnt_next;
            ch                 <= ch_next;
            drop_cnt           <= drop_cnt + 32'(drop_inc);
            trunc_cnt          <= trunc_cnt + 32'(trunc_inc);
            in_pkt_almost_full <= af_next;
        end
    end

    pkt_flit_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en[0]),
        .wr_flit  (wr_flit[0]),
        .wr2_en   (wr2_en[0]),
        .wr2_flit (in_flit),
        .rd_en    (out0_pkt_ready),
        .rd_flit  (head[0]),
        .rd_valid (head_valid[0]),
        .used     (used[0])
    );

    pkt_flit_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en[1]),
        .wr_flit  (wr_flit[1]),
        .wr2_en   (wr2_en[1]),
        .wr2_flit (in_flit),
        .rd_en    (out1_pkt_ready),
        .rd_flit  (head[1]),
        .rd_valid (head_valid[1]),
        .used     (used[1])
    );

    assign out0_pkt_valid = head_valid[0];
    assign out0_pkt_data  = head[0].data;
    assign out0_pkt_sop   = head[0].sop;
    assign out0_pkt_eop   = head[0].eop;
    assign out0_pkt_empty = head[0].empty;
    assign out1_pkt_valid = head_valid[1];
    assign out1_pkt_data  = head[1].data;
    assign out1_pkt_sop   = head[1].sop;
    assign out1_pkt_eop   = head[1].eop;
    assign out1_pkt_empty = head[1].empty;

endmodule

// File: tb/tb_pkt_channel_demux.sv
// tb_pkt_channel_demux
//   Directed bench for pkt_channel_demux: a vector table of input flits
//   with hand-computed expected outputs per port, plus hand-written
//   sequences for backpressure, port independence and mid-packet reset.
`timescale 1ns/1ps
module tb_pkt_channel_demux;
    import pkt_channel_demux_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] in_pkt_data;
    logic         in_pkt_valid, in_pkt_sop, in_pkt_eop;
    logic [5:0]   in_pkt_empty;
    logic [1:0]   in_pkt_channel;
    logic         in_pkt_ready, in_pkt_almost_full;
    logic [511:0] out0_pkt_data, out1_pkt_data;
    logic         out0_pkt_valid, out0_pkt_sop, out0_pkt_eop, out0_pkt_ready;
    logic         out1_pkt_valid, out1_pkt_sop, out1_pkt_eop, out1_pkt_ready;
    logic [5:0]   out0_pkt_empty, out1_pkt_empty;
    logic [31:0]  drop_cnt, trunc_cnt;

    always #5 clk = ~clk;

    pkt_channel_demux dut (
        .clk(clk), .rst(rst),
        .in_pkt_data(in_pkt_data), .in_pkt_valid(in_pkt_valid),
        .in_pkt_sop(in_pkt_sop), .in_pkt_eop(in_pkt_eop),
        .in_pkt_empty(in_pkt_empty), .in_pkt_channel(in_pkt_channel),
        .in_pkt_ready(in_pkt_ready), .in_pkt_almost_full(in_pkt_almost_full),
        .out0_pkt_data(out0_pkt_data), .out0_pkt_valid(out0_pkt_valid),
        .out0_pkt_sop(out0_pkt_sop), .out0_pkt_eop(out0_pkt_eop),
        .out0_pkt_empty(out0_pkt_empty), .out0_pkt_ready(out0_pkt_ready),
        .out1_pkt_data(out1_pkt_data), .out1_pkt_valid(out1_pkt_valid),
        .out1_pkt_sop(out1_pkt_sop), .out1_pkt_eop(out1_pkt_eop),
        .out1_pkt_empty(out1_pkt_empty), .out1_pkt_ready(out1_pkt_ready),
        .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt)
    );

    int checks   = 0;
    int failures = 0;

    flit_t cap0[$];
    flit_t cap1[$];
    flit_t exp0[$];
    flit_t exp1[$];

    typedef struct {
        logic        sop;
        logic        eop;
        logic [1:0]  ch;
        logic [5:0]  empty;
        logic [31:0] tag;
        int          port;    // port receiving the flit itself, -1 none
        logic        xeop;
        logic [5:0]  xempty;
        int          mport;   // port receiving an eop marker first, -1 none
    } vec_t;

    vec_t vecs[$];

    // Inputs change #1 after posedge, so ready is stable at negedge.
    always @(negedge clk) begin
        if (out0_pkt_valid && out0_pkt_ready)
            cap0.push_back('{data: out0_pkt_data, sop: out0_pkt_sop, eop: out0_pkt_eop, empty: out0_pkt_empty});
        if (out1_pkt_valid && out1_pkt_ready)
            cap1.push_back('{data: out1_pkt_data, sop: out1_pkt_sop, eop: out1_pkt_eop, empty: out1_pkt_empty});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic flit_t mk(input logic [31:0] tag, input logic s, input logic e, input logic [5:0] em);
        flit_t f;
        f.data  = {16{tag}};
        f.sop   = s;
        f.eop   = e;
        f.empty = em;
        return f;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic check_flit(input string name, input flit_t act, input flit_t req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got tag=%0h sop=%0b eop=%0b empty=%0d want tag=%0h sop=%0b eop=%0b empty=%0d",
                     name, act.data[31:0], act.sop, act.eop, act.empty,
                     req.data[31:0], req.sop, req.eop, req.empty);
        end
    endtask

    task automatic drive(input logic s, input logic e, input logic [1:0] c,
                         input logic [5:0] em, input logic [31:0] tag);
        in_pkt_valid   = 1'b1;
        in_pkt_sop     = s;
        in_pkt_eop     = e;
        in_pkt_channel = c;
        in_pkt_empty   = em;
        in_pkt_data    = {16{tag}};
        @(posedge clk); #1;
        in_pkt_valid = 1'b0;
        in_pkt_sop   = 1'b0;
        in_pkt_eop   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic addv(input logic s, input logic e, input logic [1:0] c, input logic [5:0] em,
                        input logic [31:0] tag, input int port, input logic xeop,
                        input logic [5:0] xempty, input int mport);
        vec_t v;
        v.sop = s; v.eop = e; v.ch = c; v.empty = em; v.tag = tag;
        v.port = port; v.xeop = xeop; v.xempty = xempty; v.mport = mport;
        vecs.push_back(v);
    endtask

    task automatic cmp_queues(input string name, input int port);
        int n_exp, n_cap;
        n_exp = (port == 0) ? exp0.size() : exp1.size();
        n_cap = (port == 0) ? cap0.size() : cap1.size();
        check({name, "_count"}, n_cap, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (i < n_cap) begin
                if (port == 0) check_flit($sformatf("%s_flit%0d", name, i), cap0[i], exp0[i]);
                else           check_flit($sformatf("%s_flit%0d", name, i), cap1[i], exp1[i]);
            end
        end
    endtask

    initial begin
        int n, sops, waited;
        rst = 1'b1;
        in_pkt_valid = 1'b0; in_pkt_sop = 1'b0; in_pkt_eop = 1'b0;
        in_pkt_empty = '0; in_pkt_channel = '0; in_pkt_data = '0;
        out0_pkt_ready = 1'b1; out1_pkt_ready = 1'b1;
        idle(3);
        rst = 1'b0;

        // Reset state
        check("rst_out0_valid", out0_pkt_valid, 0);
        check("rst_out1_valid", out1_pkt_valid, 0);
        check("rst_af", in_pkt_almost_full, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_trunc", trunc_cnt, 0);
        check("in_ready", in_pkt_ready, 1);

        // One-flit ch0 packet visible on out0 the cycle after it is accepted
        drive(1, 1, 2'd0, 6'd0, 32'hA0);
        check("t1_out0_valid", out0_pkt_valid, 1);
        check_flit("t1_head", '{data: out0_pkt_data, sop: out0_pkt_sop, eop: out0_pkt_eop, empty: out0_pkt_empty},
                   mk(32'hA0, 1, 1, 0));
        idle(2);
        check("t1_out0_drained", out0_pkt_valid, 0);
        cap0.delete(); cap1.delete();

        // Vector table
        addv(1, 0, 2'd1, 0, 32'h10, 1, 0, 0, -1);
        addv(0, 0, 2'd1, 0, 32'h11, 1, 0, 0, -1);
        addv(0, 1, 2'd1, 5, 32'h12, 1, 1, 5, -1);
        for (int i = 1; i <= 40; i++)
            addv(i == 1, i == 40, 2'd0, (i == 32) ? 6'd3 : ((i == 40) ? 6'd7 : 6'd0),
                 32'h200 + i, (i <= 32) ? 0 : -1, i == 32, 0, -1);
        addv(1, 0, 2'd0, 0, 32'h30, 0, 0, 0, -1);
        addv(0, 1, 2'd0, 2, 32'h31, 0, 1, 2, -1);
        for (int i = 0; i < 5; i++)
            addv(i == 0, i == 4, 2'd2, 0, 32'h40 + i, -1, 0, 0, -1);
        addv(1, 1, 2'd3, 0, 32'h45, -1, 0, 0, -1);
        addv(1, 0, 2'd0, 0, 32'h50, 0, 0, 0, -1);
        addv(0, 0, 2'd0, 0, 32'h51, 0, 0, 0, -1);
        addv(1, 0, 2'd1, 0, 32'h52, 1, 0, 0, 0);
        addv(0, 1, 2'd1, 9, 32'h53, 1, 1, 9, -1);
        addv(1, 0, 2'd0, 0, 32'h60, 0, 0, 0, -1);
        addv(1, 1, 2'd0, 4, 32'h61, 0, 1, 4, 0);
        addv(0, 0, 2'd1, 0, 32'h70, -1, 0, 0, -1);
        addv(1, 1, 2'd1, 1, 32'h71, 1, 1, 1, -1);

        foreach (vecs[i]) begin
            if (vecs[i].mport == 0) exp0.push_back(mk(vecs[i].tag, 0, 1, 0));
            if (vecs[i].mport == 1) exp1.push_back(mk(vecs[i].tag, 0, 1, 0));
            if (vecs[i].port == 0) exp0.push_back(mk(vecs[i].tag, vecs[i].sop, vecs[i].xeop, vecs[i].xempty));
            if (vecs[i].port == 1) exp1.push_back(mk(vecs[i].tag, vecs[i].sop, vecs[i].xeop, vecs[i].xempty));
        end
        foreach (vecs[i])
            drive(vecs[i].sop, vecs[i].eop, vecs[i].ch, vecs[i].empty, vecs[i].tag);
        idle(6);
        cmp_queues("tbl_out0", 0);
        cmp_queues("tbl_out1", 1);
        check("tbl_drop", drop_cnt, 2);
        check("tbl_trunc", trunc_cnt, 3);

        // Backpressure: out1 stalled, 4-flit ch1 packets back-to-back
        rst = 1'b1; idle(1); rst = 1'b0;
        cap0.delete(); cap1.delete();
        out1_pkt_ready = 1'b0;
        for (int pk = 0; pk < 130; pk++) begin
            for (int f = 0; f < 4; f++) begin
                drive(f == 0, f == 3, 2'd1, 0, (pk << 8) | f);
                n = 4 * pk + f + 1;
                if (pk < 121 && n == 447) check("af_below", in_pkt_almost_full, 0);
                if (pk < 121 && n == 448) check("af_rise", in_pkt_almost_full, 1);
            end
        end
        check("bp_drop", drop_cnt, 9);
        check("bp_af_held", in_pkt_almost_full, 1);
        check("bp_out1_valid", out1_pkt_valid, 1);

        // Port independence: ch0 flows at full rate while out1 is stalled
        for (int pk = 0; pk < 5; pk++) begin
            for (int f = 0; f < 3; f++) begin
                drive(f == 0, f == 2, 2'd0, 0, 32'h900 + pk * 4 + f);
                check($sformatf("ind_out0_valid%0d", pk * 3 + f), out0_pkt_valid, 1);
            end
            if (pk == 2)
                for (int f = 0; f < 4; f++) drive(f == 0, f == 3, 2'd1, 0, 32'hBAD);
        end
        idle(3);
        check("ind_out0_count", cap0.size(), 15);
        check("ind_out0_last", cap0.size() == 15 ? cap0[14].data[31:0] : 32'hFFFF_FFFF, 32'h900 + 4 * 4 + 2);
        check("ind_drop", drop_cnt, 10);
        check("ind_out1_count", cap1.size(), 0);

        // Drain out1 backlog, bounded
        out1_pkt_ready = 1'b1;
        waited = 0;
        while (out1_pkt_valid && waited < 1000) begin idle(1); waited++; end
        check("drain_timeout", waited < 1000, 1);
        idle(2);
        check("drain_count", cap1.size(), 484);
        sops = 0;
        foreach (cap1[i]) if (cap1[i].sop) sops++;
        check("drain_sops", sops, 121);
        check("drain_last", cap1.size() > 0 ? {cap1[cap1.size()-1].data[31:0]} : 32'hFFFF_FFFF,
              (120 << 8) | 3);
        check("drain_af", in_pkt_almost_full, 0);

        // Reset mid 10-flit packet after flit 4
        cap0.delete(); cap1.delete();
        out0_pkt_ready = 1'b0;
        for (int i = 1; i <= 4; i++) drive(i == 1, 0, 2'd0, 0, 32'hC00 + i);
        check("rm_out0_held", out0_pkt_valid, 1);
        rst = 1'b1;
        drive(0, 0, 2'd0, 0, 32'hC05);
        rst = 1'b0;
        check("rm_out0_valid", out0_pkt_valid, 0);
        check("rm_out1_valid", out1_pkt_valid, 0);
        check("rm_drop", drop_cnt, 0);
        check("rm_trunc", trunc_cnt, 0);
        check("rm_af", in_pkt_almost_full, 0);
        out0_pkt_ready = 1'b1;
        for (int i = 6; i <= 10; i++) drive(0, i == 10, 2'd0, 0, 32'hC00 + i);
        drive(1, 0, 2'd0, 0, 32'hD0);
        drive(0, 1, 2'd0, 3, 32'hD1);
        idle(4);
        exp0.delete();
        exp0.push_back(mk(32'hD0, 1, 0, 0));
        exp0.push_back(mk(32'hD1, 0, 1, 3));
        exp1.delete();
        cmp_queues("rm_out0", 0);
        cmp_queues("rm_out1", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
